// File: rtl/slice_add_scheduler.sv
// rtl/slice_add_scheduler.sv - round-robin shared SLICE-bit adder computing WIDTH-bit sums serially
module slice_add_scheduler #(
  parameter int WIDTH = 12,
  parameter int SLICE = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             owner
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic             rr_ptr;
  logic [KW-1:0]    k;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             owner_reg;
  logic [SLICE:0]   slice_sum;
  logic             gnt_valid;
  logic             gnt;

  // The one shared narrow adder; operands are selected by the slice index.
  always_comb begin
    slice_sum = {1'b0, a_reg[int'(k)*SLICE +: SLICE]}
              + {1'b0, b_reg[int'(k)*SLICE +: SLICE]}
              + {{SLICE{1'b0}}, carry};
  end

  // A lone requester wins outright; a tie goes to the round-robin pointer.
  assign gnt_valid = req0 | req1;
  assign gnt       = (req0 & req1) ? rr_ptr : req1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      k         <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      owner_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            owner_reg <= gnt;
            a_reg     <= gnt ? a1 : a0;
            b_reg     <= gnt ? b1 : b0;
            carry     <= 1'b0;
            k         <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          sum_reg[int'(k)*SLICE +: SLICE] <= slice_sum[SLICE-1:0];
          carry <= slice_sum[SLICE];
          if (k == KW'(NSLICE - 1)) begin
            cout_reg <= slice_sum[SLICE];
            state    <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          rr_ptr <= ~owner_reg;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ack0  = (state == DONE) && !owner_reg;
  assign ack1  = (state == DONE) && owner_reg;
  assign busy  = (state == RUN) || (state == DONE);
  assign sum   = sum_reg;
  assign cout  = cout_reg;
  assign owner = owner_reg;

endmodule

// File: tb/tb_slice_add_scheduler.sv
// tb/tb_slice_add_scheduler.sv - table vectors, corner sequences and random traffic against an arithmetic model
module tb_slice_add_scheduler;

  localparam int WIDTH = 12;
  localparam int SLICE = 3;
  localparam int LAT   = WIDTH / SLICE + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0, req1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             ack0, ack1, cout, busy, owner;
  logic [WIDTH-1:0] sum;

  int checks = 0;
  int errors = 0;

  slice_add_scheduler #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .sum(sum), .cout(cout),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             who;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    bit               chg;
    logic [WIDTH-1:0] chg_a;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Issues one request and follows it to its ack, starting from IDLE at #1 after an edge.
  task automatic do_op(input vec_t v, input string tag);
    int  lat;
    int  busy_cnt;
    bit  got;
    bit  other;
    lat = 0; busy_cnt = 0; got = 0; other = 0;
    if (v.who) begin a1 = v.a; b1 = v.b; req1 = 1'b1; end
    else       begin a0 = v.a; b0 = v.b; req0 = 1'b1; end
    for (int i = 1; i <= 20 && !got; i++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (v.chg && i == 2) begin
        if (v.who) a1 = v.chg_a; else a0 = v.chg_a;
      end
      if (v.who ? ack0 : ack1) other = 1;
      if (v.who ? ack1 : ack0) begin
        got = 1;
        lat = i;
        check({tag, "_sum"},   32'(sum),   32'(v.exp_sum));
        check({tag, "_cout"},  32'(cout),  32'(v.exp_cout));
        check({tag, "_owner"}, 32'(owner), 32'(v.who));
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check({tag, "_latency"},   32'(lat),      32'(LAT));
    check({tag, "_busy_cyc"},  32'(busy_cnt), 32'(LAT));
    check({tag, "_other_ack"}, 32'(other),    32'd0);
    @(posedge clk); #1;
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic reset_mid_run();
    vec_t v;
    req1 = 1'b1; a1 = 12'h555; b1 = 12'h0AA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy_pre",  32'(busy),  32'd1);
    check("mid_owner_pre", 32'(owner), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", 32'({ack0, ack1, busy, cout, owner}), 32'd0);
    check("mid_rst_sum",  32'(sum), 32'd0);
    req1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_held", 32'({ack0, ack1, busy}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    v = '{1'b0, 12'h007, 12'h001, 1'b0, 12'h000, 12'h008, 1'b0};
    do_op(v, "after_rst");
  endtask

  // Both requesters keep asking; each ack is scored against that requester's own operands.
  task automatic fair_test();
    logic [WIDTH-1:0] ea[2];
    logic [WIDTH-1:0] eb[2];
    logic [WIDTH:0]   exp13;
    int               order[$];
    int               t_ack[$];
    int               w;
    do_reset();
    ea[0] = 12'h001; eb[0] = 12'h001; ea[1] = 12'h800; eb[1] = 12'h800;
    a0 = ea[0]; b0 = eb[0]; a1 = ea[1]; b1 = eb[1];
    req0 = 1'b1; req1 = 1'b1;
    for (int cyc = 1; cyc <= 100 && order.size() < 6; cyc++) begin
      @(posedge clk); #1;
      if (ack0 && ack1) check("fair_dual_ack", 32'd1, 32'd0);
      if (ack0 || ack1) begin
        w = ack1 ? 1 : 0;
        exp13 = {1'b0, ea[w]} + {1'b0, eb[w]};
        check($sformatf("fair_res%0d", order.size()), 32'({cout, sum}), 32'(exp13));
        order.push_back(w);
        t_ack.push_back(cyc);
        ea[w] = WIDTH'($urandom);
        eb[w] = WIDTH'($urandom);
        if (w == 1) begin a1 = ea[1]; b1 = eb[1]; end
        else        begin a0 = ea[0]; b0 = eb[0]; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("fair_count", 32'(order.size()), 32'd6);
    if (order.size() == 6) begin
      for (int i = 0; i < 6; i++) check($sformatf("fair_order%0d", i), 32'(order[i]), 32'(i % 2));
      check("fair_first_lat", 32'(t_ack[0]), 32'(LAT));
      for (int i = 1; i < 6; i++)
        check($sformatf("fair_gap%0d", i), 32'(t_ack[i] - t_ack[i-1]), 32'(LAT + 1));
    end
    repeat (LAT + 2) @(posedge clk);
    #1;
  endtask

  task automatic random_test();
    logic [WIDTH-1:0] ra[2];
    logic [WIDTH-1:0] rb[2];
    logic [WIDTH:0]   exp13;
    bit               pend[2];
    bit               ackw;
    pend[0] = 0; pend[1] = 0;
    for (int cyc = 0; cyc < 460; cyc++) begin
      @(posedge clk); #1;
      if (ack0 && ack1) check("rand_dual_ack", 32'd1, 32'd0);
      for (int w = 0; w < 2; w++) begin
        ackw = (w == 1) ? ack1 : ack0;
        if (ackw) begin
          if (!pend[w]) check("rand_spurious_ack", 32'd1, 32'd0);
          else begin
            exp13 = {1'b0, ra[w]} + {1'b0, rb[w]};
            check("rand_res", 32'({cout, sum}), 32'(exp13));
          end
          pend[w] = 0;
          if (w == 1) req1 = 1'b0; else req0 = 1'b0;
        end
      end
      if (cyc < 400) begin
        for (int w = 0; w < 2; w++) begin
          if (!pend[w] && $urandom_range(0, 3) == 0) begin
            ra[w] = WIDTH'($urandom);
            rb[w] = WIDTH'($urandom);
            pend[w] = 1;
            if (w == 1) begin a1 = ra[1]; b1 = rb[1]; req1 = 1'b1; end
            else        begin a0 = ra[0]; b0 = rb[0]; req0 = 1'b1; end
          end
        end
      end
    end
    check("rand_drained", 32'({pend[1], pend[0]}), 32'd0);
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    vecs[0] = '{1'b0, 12'h123, 12'h456, 1'b0, 12'h000, 12'h579, 1'b0};
    vecs[1] = '{1'b1, 12'hFFF, 12'h001, 1'b0, 12'h000, 12'h000, 1'b1};
    vecs[2] = '{1'b0, 12'h00F, 12'h001, 1'b1, 12'hFFF, 12'h010, 1'b0};
    vecs[3] = '{1'b1, 12'h800, 12'h800, 1'b0, 12'h000, 12'h000, 1'b1};
    vecs[4] = '{1'b0, 12'hABC, 12'h544, 1'b0, 12'h000, 12'h000, 1'b1};
    vecs[5] = '{1'b1, 12'h7FF, 12'h7FF, 1'b0, 12'h000, 12'hFFE, 1'b0};
    #1;
    check("rst_outs", 32'({ack0, ack1, busy, cout, owner}), 32'd0);
    check("rst_sum",  32'(sum), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) do_op(vecs[i], $sformatf("vec%0d", i));
    reset_mid_run();
    fair_test();
    random_test();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
